// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: CHUNK bits per stage, carry registered
// between stages, valid/ready handshake with a global stall.
module pipelined_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int STAGES = WIDTH / CHUNK;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  logic             advance;
  logic             in_vld_q;
  logic             in_c_q;
  logic [WIDTH-1:0] in_a_q;
  logic [WIDTH-1:0] in_b_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Input register: B and the carry are inverted here so every stage just adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_vld_q <= 1'b0;
      in_c_q   <= 1'b0;
      in_a_q   <= '0;
      in_b_q   <= '0;
    end else if (advance) begin
      in_vld_q <= in_valid;
      in_c_q   <= cin ^ sub;
      in_a_q   <= a;
      in_b_q   <= b ^ {WIDTH{sub}};
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RIN = WIDTH - k * CHUNK;
    localparam int SW  = (k + 1) * CHUNK;

    logic           prev_vld;
    logic           prev_c;
    logic [RIN-1:0] prev_a;
    logic [RIN-1:0] prev_b;
    logic [CHUNK:0] part;
    logic [SW-1:0]  s_d;
    logic [SW-1:0]  s_q;
    logic           vld_q;
    logic           c_q;

    if (k == 0) begin : g_src
      assign prev_vld = in_vld_q;
      assign prev_c   = in_c_q;
      assign prev_a   = in_a_q;
      assign prev_b   = in_b_q;
      assign s_d      = part[CHUNK-1:0];
    end else begin : g_chain
      assign prev_vld = g_stage[k-1].vld_q;
      assign prev_c   = g_stage[k-1].c_q;
      assign prev_a   = g_stage[k-1].g_fwd.a_q;
      assign prev_b   = g_stage[k-1].g_fwd.b_q;
      assign s_d      = {part[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign part = chunk_add(prev_a[CHUNK-1:0], prev_b[CHUNK-1:0], prev_c);

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else if (advance) begin
        vld_q <= prev_vld;
        c_q   <= part[CHUNK];
        s_q   <= s_d;
      end
    end

    // Only the operand bits not yet consumed travel on to later stages.
    if (RIN > CHUNK) begin : g_fwd
      logic [RIN-CHUNK-1:0] a_q;
      logic [RIN-CHUNK-1:0] b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= prev_a[RIN-1:CHUNK];
          b_q <= prev_b[RIN-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_q;
      // Same-sign operands giving an opposite-sign result == carry-in(MSB) ^ carry-out.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (prev_a[RIN-1] ~^ prev_b[RIN-1]) & (part[CHUNK-1] ^ prev_a[RIN-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: default 8/2 build plus the 2/1 and 8/8 corners.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] a8, b8, sum8;
  logic       cin8, sub8, iv8, ir8, co8, ov8, vo8, or8;
  logic [1:0] a2, b2, sum2;
  logic       cin2, sub2, iv2, ir2, co2, ov2, vo2, or2;
  logic [7:0] aw, bw, sumw;
  logic       cinw, subw, ivw, irw, cow, ovw, vow, orw;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .in_valid(iv8), .in_ready(ir8), .sum(sum8), .cout(co8), .overflow(ov8),
    .out_valid(vo8), .out_ready(or8));

  pipelined_adder #(.WIDTH(2), .CHUNK(1)) u_w2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .in_valid(iv2), .in_ready(ir2), .sum(sum2), .cout(co2), .overflow(ov2),
    .out_valid(vo2), .out_ready(or2));

  pipelined_adder #(.WIDTH(8), .CHUNK(8)) u_w8 (
    .clk(clk), .rst(rst), .a(aw), .b(bw), .cin(cinw), .sub(subw),
    .in_valid(ivw), .in_ready(irw), .sum(sumw), .cout(cow), .overflow(ovw),
    .out_valid(vow), .out_ready(orw));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (vo8 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", vo8); end
    n_cmp++; if (ir8 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", ir8); end
    n_cmp++; if (sum8 !== 8'h00) begin n_bad++; $display("FAIL reset_sum: got %h expected 00", sum8); end
    n_cmp++; if (co8 !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b expected 0", co8); end
    n_cmp++; if (ov8 !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", ov8); end
    n_cmp++; if ({vo2, vow} !== 2'b00) begin n_bad++; $display("FAIL reset_corner_valid: got %b expected 00", {vo2, vow}); end
    n_cmp++; if ({ir2, irw} !== 2'b11) begin n_bad++; $display("FAIL reset_corner_ready: got %b expected 11", {ir2, irw}); end
    rst = 1'b0;
  endtask

  task automatic test_add_latency();
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4) begin
        n_cmp++; if (vo8 !== 1'b0) begin n_bad++; $display("FAIL add_early_valid: cycle %0d got %b expected 0", i, vo8); end
      end else begin
        n_cmp++; if (vo8 !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b expected 1", vo8); end
        n_cmp++; if (sum8 !== 8'h00) begin n_bad++; $display("FAIL add_sum: got %h expected 00", sum8); end
        n_cmp++; if (co8 !== 1'b1) begin n_bad++; $display("FAIL add_cout: got %b expected 1", co8); end
        n_cmp++; if (ov8 !== 1'b0) begin n_bad++; $display("FAIL add_overflow: got %b expected 0", ov8); end
      end
    end
  endtask

  task automatic test_add_overflow();
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    n_cmp++; if (vo8 !== 1'b1) begin n_bad++; $display("FAIL ovf_valid: got %b expected 1", vo8); end
    n_cmp++; if (sum8 !== 8'h80) begin n_bad++; $display("FAIL ovf_sum: got %h expected 80", sum8); end
    n_cmp++; if (co8 !== 1'b0) begin n_bad++; $display("FAIL ovf_cout: got %b expected 0", co8); end
    n_cmp++; if (ov8 !== 1'b1) begin n_bad++; $display("FAIL ovf_overflow: got %b expected 1", ov8); end
  endtask

  task automatic test_subtract();
    logic [7:0] va [3] = '{8'h05, 8'h80, 8'h10};
    logic [7:0] vb [3] = '{8'h07, 8'h01, 8'h03};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es [3] = '{8'hFE, 8'h7F, 8'h0C};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    logic       eo [3] = '{1'b0, 1'b1, 1'b0};
    int got = 0;
    for (int j = 0; j < 3; j++) begin
      a8 = va[j]; b8 = vb[j]; cin8 = vc[j]; sub8 = 1'b1; iv8 = 1'b1;
      tick();
    end
    iv8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0;
    for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
      if (vo8 === 1'b1) begin
        n_cmp++; if (sum8 !== es[got]) begin n_bad++; $display("FAIL sub_sum[%0d]: got %h expected %h", got, sum8, es[got]); end
        n_cmp++; if (co8 !== ec[got]) begin n_bad++; $display("FAIL sub_cout[%0d]: got %b expected %b", got, co8, ec[got]); end
        n_cmp++; if (ov8 !== eo[got]) begin n_bad++; $display("FAIL sub_overflow[%0d]: got %b expected %b", got, ov8, eo[got]); end
        got++;
      end
      tick();
    end
    n_cmp++; if (got != 3) begin n_bad++; $display("FAIL sub_count: got %0d results expected 3", got); end
  endtask

  task automatic test_backpressure();
    logic [7:0] res [6];
    logic [7:0] hs;
    logic       hc, ho;
    int issued = 0, got = 0, stall_left = 0, seen = 0;
    bit stall_done = 1'b0;
    sub8 = 1'b0; cin8 = 1'b0; or8 = 1'b1;
    hs = 8'h00; hc = 1'b0; ho = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (stall_left > 0) begin
        n_cmp++; if (vo8 !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid: got %b expected 1", vo8); end
        n_cmp++; if ({sum8, co8, ov8} !== {hs, hc, ho}) begin n_bad++; $display("FAIL bp_hold_data: got %h/%b/%b expected %h/%b/%b", sum8, co8, ov8, hs, hc, ho); end
      end
      if (!stall_done && vo8 === 1'b1) begin
        stall_done = 1'b1; stall_left = 3; hs = sum8; hc = co8; ho = ov8; or8 = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) or8 = 1'b1;
      end
      if (issued < 6) begin
        iv8 = 1'b1; a8 = 8'(issued + 1); b8 = 8'(issued + 1);
      end else begin
        iv8 = 1'b0;
      end
      #1;
      if (or8 == 1'b0) begin
        n_cmp++; if (ir8 !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b expected 0", ir8); end
      end
      if (vo8 === 1'b1 && or8 == 1'b1) begin
        res[got] = sum8;
        got++;
      end
      if (iv8 && ir8 === 1'b1) issued++;
      tick();
    end
    iv8 = 1'b0;
    n_cmp++; if (got != 6) begin n_bad++; $display("FAIL bp_count: got %0d results expected 6", got); end
    n_cmp++; if (!stall_done) begin n_bad++; $display("FAIL bp_stall: got no valid result expected a stall"); end
    for (int i = 0; i < got; i++) begin
      n_cmp++; if (res[i] !== 8'(2 * (i + 1))) begin n_bad++; $display("FAIL bp_order[%0d]: got %h expected %h", i, res[i], 8'(2 * (i + 1))); end
    end
    for (int i = 0; i < 6; i++) begin
      if (vo8 !== 1'b0) seen++;
      tick();
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL bp_duplicate: got %0d extra valid cycles expected 0", seen); end
  endtask

  task automatic test_reset_midflight();
    logic [7:0] va [3] = '{8'h11, 8'h44, 8'h20};
    logic [7:0] vb [3] = '{8'h22, 8'h11, 8'h20};
    int seen = 0;
    or8 = 1'b1; sub8 = 1'b0; cin8 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      a8 = va[j]; b8 = vb[j]; iv8 = 1'b1;
      tick();
    end
    iv8 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (vo8 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b expected 0", vo8); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vo8 !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_mid_ghost: got %0d valid cycles expected 0", seen); end
    a8 = 8'h01; b8 = 8'h01; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    n_cmp++; if (vo8 !== 1'b1) begin n_bad++; $display("FAIL rst_new_valid: got %b expected 1", vo8); end
    n_cmp++; if (sum8 !== 8'h02) begin n_bad++; $display("FAIL rst_new_sum: got %h expected 02", sum8); end
  endtask

  task automatic test_corners();
    a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1; iv2 = 1'b1;
    aw = 8'hFF; bw = 8'h01; cinw = 1'b0; ivw = 1'b1;
    tick();
    iv2 = 1'b0; ivw = 1'b0;
    tick();
    n_cmp++; if (vow !== 1'b1) begin n_bad++; $display("FAIL c8_valid: got %b expected 1", vow); end
    n_cmp++; if (sumw !== 8'h00) begin n_bad++; $display("FAIL c8_sum: got %h expected 00", sumw); end
    n_cmp++; if (cow !== 1'b1) begin n_bad++; $display("FAIL c8_cout: got %b expected 1", cow); end
    n_cmp++; if (ovw !== 1'b0) begin n_bad++; $display("FAIL c8_overflow: got %b expected 0", ovw); end
    n_cmp++; if (vo2 !== 1'b0) begin n_bad++; $display("FAIL c2_early_valid: got %b expected 0", vo2); end
    tick();
    n_cmp++; if (vo2 !== 1'b1) begin n_bad++; $display("FAIL c2_valid: got %b expected 1", vo2); end
    n_cmp++; if (sum2 !== 2'b11) begin n_bad++; $display("FAIL c2_sum: got %b expected 11", sum2); end
    n_cmp++; if (co2 !== 1'b1) begin n_bad++; $display("FAIL c2_cout: got %b expected 1", co2); end
    n_cmp++; if (ov2 !== 1'b0) begin n_bad++; $display("FAIL c2_overflow: got %b expected 0", ov2); end
  endtask

  initial begin
    rst = 1'b1;
    a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
    a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0; iv2 = 1'b0; or2 = 1'b1;
    aw = '0; bw = '0; cinw = 1'b0; subw = 1'b0; ivw = 1'b0; orw = 1'b1;
    test_reset();
    test_add_latency();
    test_add_overflow();
    test_subtract();
    test_backpressure();
    test_reset_midflight();
    test_corners();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
